lspc_linebuf: RTL and testbench

- Sprite line-buffer writer/reader directly downstream of the ZMC2 dot shifter.
- Consumes the per-12M-tick pixel pair (GAD/GBD color indices, DOTA/DOTB opacity) plus the tile palette.
- Writes opaque pixels into a ping-pong pair of line buffers at a running X address.
- On the display side, reads the other buffer set, returns a 12-bit palette/color index, and clears each entry after it is read.

---
 rtl/neo_lb_pkg.sv | 13 +
 rtl/lspc_linebuf_if.sv | 30 +++
 rtl/lb_bank_ram.sv | 27 ++
 rtl/lspc_linebuf.sv | 122 ++++++++++++
 tb/tb_lspc_linebuf.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/neo_lb_pkg.sv
// Shared constants and types for the sprite line-buffer writer/reader.
package neo_lb_pkg;

  localparam int unsigned XW           = 9;
  localparam int unsigned COLW         = 12;
  localparam int unsigned RAM_AW       = 8;
  localparam int unsigned PAIRS        = 4;
  localparam int unsigned PW           = $clog2(PAIRS);
  localparam int unsigned LINE_VISIBLE = 320;

  typedef enum logic {IDLE, WRITE} lb_state_e;

endpackage

// File: rtl/lspc_linebuf_if.sv
// Shifter-side write signals and display-side read signals of the line buffer.
interface lspc_linebuf_if;
  import neo_lb_pkg::*;

  logic            clk_en_12m_n;
  logic            load;
  logic [XW-1:0]   x_start;
  logic [7:0]      pal;
  logic [3:0]      gad;
  logic [3:0]      gbd;
  logic            dota;
  logic            dotb;
  logic            line_swap;
  logic            rd_en;
  logic [XW-1:0]   rd_x;
  logic [COLW-1:0] rd_color;
  logic            busy;
  logic            done;

  modport master (
    output clk_en_12m_n, load, x_start, pal, gad, gbd, dota, dotb, line_swap, rd_en, rd_x,
    input  rd_color, busy, done
  );

  modport slave (
    input  clk_en_12m_n, load, x_start, pal, gad, gbd, dota, dotb, line_swap, rd_en, rd_x,
    output rd_color, busy, done
  );

endinterface

// File: rtl/lb_bank_ram.sv
// 256x12 RAM, one synchronous write and one synchronous read port; reads return old data.
module lb_bank_ram
  import neo_lb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [COLW-1:0]   wdata,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [COLW-1:0]   rdata
);

  logic [COLW-1:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds until the next read so the display sees a stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lspc_linebuf.sv
// Ping-pong sprite line buffer: strip writer on the 12M tick, clear-after-read display port.
module lspc_linebuf
  import neo_lb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  lspc_linebuf_if.slave  bus
);

  lb_state_e       state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [7:0]      pal_q, pal_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic            wset_q, wset_d;
  logic            done_q, done_d;
  logic [1:0]      rd_sel_q;
  logic            wr_a, wr_b;
  logic            tick;
  logic [RAM_AW-1:0] even_idx, odd_idx;
  logic [3:0][COLW-1:0] ram_rdata;

  assign tick     = bus.clk_en_12m_n;
  assign odd_idx  = x_q[XW-1:1];
  assign even_idx = x_q[XW-1:1] + RAM_AW'(x_q[0]);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    pal_d   = pal_q;
    pair_d  = pair_q;
    wset_d  = wset_q;
    done_d  = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && bus.load) begin
          x_d     = bus.x_start;
          pal_d   = bus.pal;
          pair_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (tick && bus.load) begin
          x_d    = bus.x_start;
          pal_d  = bus.pal;
          pair_d = '0;
        end else if (tick) begin
          wr_a   = bus.dota;
          wr_b   = bus.dotb;
          x_d    = x_q + XW'(2);
          pair_d = pair_q + PW'(1);
          if (pair_q == PW'(PAIRS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A coincident write still lands in the old set; the strip itself is abandoned.
    if (bus.line_swap) begin
      wset_d = ~wset_q;
      if (state_q == WRITE) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      pal_q    <= '0;
      pair_q   <= '0;
      wset_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_sel_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      pal_q   <= pal_d;
      pair_q  <= pair_d;
      wset_q  <= wset_d;
      done_q  <= done_d;
      if (bus.rd_en) rd_sel_q <= {~wset_q, bus.rd_x[0]};
    end
  end

  // Bank index = {set, odd}; write-set banks take the writer, read-set banks take the clear.
  for (genvar i = 0; i < 4; i++) begin : g_ram
    localparam logic RamSet = (i >= 2);
    localparam logic RamOdd = ((i % 2) == 1);
    logic              we, re, hit;
    logic [RAM_AW-1:0] waddr;
    logic [COLW-1:0]   wdata;

    assign hit   = bus.rd_en && (bus.rd_x[0] == RamOdd);
    assign re    = hit && (wset_q != RamSet);
    assign we    = (wset_q == RamSet) ? (RamOdd ? wr_b : wr_a) : hit;
    assign waddr = (wset_q == RamSet) ? (RamOdd ? odd_idx : even_idx) : bus.rd_x[XW-1:1];
    assign wdata = (wset_q == RamSet) ? {pal_q, (RamOdd ? bus.gbd : bus.gad)} : '0;

    lb_bank_ram u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re),
      .raddr (bus.rd_x[XW-1:1]),
      .rdata (ram_rdata[i])
    );
  end

  assign bus.rd_color = ram_rdata[rd_sel_q];
  assign bus.busy     = (state_q == WRITE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_lspc_linebuf.sv
// Directed bench for lspc_linebuf: strip writes, set swaps, clear-after-read, wrap and abort.
module tb_lspc_linebuf;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [11:0] c;

  lspc_linebuf_if bus ();

  lspc_linebuf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic ld, input logic [8:0] xs, input logic [7:0] p,
                      input logic [3:0] a, input logic [3:0] b, input logic da, input logic db);
    @(negedge clk);
    bus.clk_en_12m_n = 1'b1;
    bus.load         = ld;
    bus.x_start      = xs;
    bus.pal          = p;
    bus.gad          = a;
    bus.gbd          = b;
    bus.dota         = da;
    bus.dotb         = db;
    @(negedge clk);
    bus.clk_en_12m_n = 1'b0;
    bus.load         = 1'b0;
  endtask

  // Load then four pairs: gad = a0+i, gbd = b0+i.
  task automatic strip(input logic [8:0] xs, input logic [7:0] p, input logic [3:0] a0,
                       input logic [3:0] b0, input logic da, input logic db);
    tick(1'b1, xs, p, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 9'd0, 8'd0, a0 + 4'(i), b0 + 4'(i), da, db);
  endtask

  task automatic rd(input logic [8:0] x, output logic [11:0] col);
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.rd_x  = x;
    @(negedge clk);
    bus.rd_en = 1'b0;
    col = bus.rd_color;
  endtask

  task automatic swap();
    @(negedge clk);
    bus.line_swap = 1'b1;
    @(negedge clk);
    bus.line_swap = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_a [8];
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.clk_en_12m_n = 1'b0;
    bus.load = 1'b0;
    bus.x_start = '0;
    bus.pal = '0;
    bus.gad = '0;
    bus.gbd = '0;
    bus.dota = 1'b0;
    bus.dotb = 1'b0;
    bus.line_swap = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_x = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_color", 32'(bus.rd_color), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;

    // Clear sweep of set 1, then set 0, ending with set 0 as write set.
    for (int x = 0; x < 512; x++) rd(9'(x), c);
    swap();
    for (int x = 0; x < 512; x++) rd(9'(x), c);
    swap();

    tick(1'b1, 9'd10, 8'h23, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("load_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 4; i++) tick(1'b0, 9'd0, 8'd0, 4'(1 + i), 4'(5 + i), 1'b1, 1'b1);
    chk("strip_done", 32'(bus.done), 32'h1);
    chk("strip_busy_end", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("done_pulse_end", 32'(bus.done), 32'h0);
    swap();
    exp_a = '{12'h231, 12'h235, 12'h232, 12'h236, 12'h233, 12'h237, 12'h234, 12'h238};
    for (int i = 0; i < 8; i++) begin
      rd(9'(10 + i), c);
      chk($sformatf("strip_x%0d", 10 + i), 32'(c), 32'(exp_a[i]));
    end
    swap();
    swap();
    rd(9'd10, c);
    chk("clear_after_read", 32'(c), 32'h0);

    // Write set is now 1: opaque strip then odd-only strip over it.
    strip(9'd20, 8'h01, 4'h1, 4'h5, 1'b1, 1'b1);
    chk("s1_done", 32'(bus.done), 32'h1);
    strip(9'd20, 8'h02, 4'h9, 4'h9, 1'b0, 1'b1);
    swap();
    exp_a = '{12'h011, 12'h029, 12'h012, 12'h02a, 12'h013, 12'h02b, 12'h014, 12'h02c};
    for (int i = 0; i < 8; i++) begin
      rd(9'(20 + i), c);
      chk($sformatf("overlay_x%0d", 20 + i), 32'(c), 32'(exp_a[i]));
    end

    // Write set 0: X wrap at 511.
    tick(1'b1, 9'd511, 8'h10, 4'h0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 9'd0, 8'd0, 4'h9, 4'h3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 9'd0, 8'd0, 4'hf, 4'hf, 1'b0, 1'b0);
    swap();
    rd(9'd511, c);
    chk("wrap_x511", 32'(c), 32'h103);
    rd(9'd0, c);
    chk("wrap_x0", 32'(c), 32'h109);
    rd(9'd1, c);
    chk("wrap_x1", 32'(c), 32'h0);

    // Write set 1: abandon after two pairs.
    tick(1'b1, 9'd40, 8'h05, 4'h0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 9'd0, 8'd0, 4'h1, 4'h5, 1'b1, 1'b1);
    tick(1'b0, 9'd0, 8'd0, 4'h2, 4'h6, 1'b1, 1'b1);
    swap();
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done0", 32'(bus.done), 32'h0);
    tick(1'b0, 9'd0, 8'd0, 4'h7, 4'h7, 1'b1, 1'b1);
    chk("abort_done1", 32'(bus.done), 32'h0);
    chk("abort_busy1", 32'(bus.busy), 32'h0);
    rd(9'd40, c);
    chk("abort_x40", 32'(c), 32'h051);
    rd(9'd43, c);
    chk("abort_x43", 32'(c), 32'h056);
    swap();
    rd(9'd44, c);
    chk("abort_x44", 32'(c), 32'h0);
    rd(9'd45, c);
    chk("abort_x45", 32'(c), 32'h0);

    // LOAD held under reset must not start a strip.
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 9'd60, 8'h44, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_load_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_color", 32'(bus.rd_color), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
